risc_controller: RTL

Instruction register, decoder and multi-cycle FSM that sequences the 16-bit datapath (regfile, A/B/C registers, shifter, ALU, status) plus PC, address register and memory.
Fetches from memory, decodes the 3-bit opcode/2-bit op, and drives every datapath control per cycle.
The PC counter, address register, address mux and memory are external; this block only drives their controls.

---
 rtl/risc_controller.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/risc_controller.sv
// Multi-cycle controller for the 16-bit datapath: holds the instruction register,
// decodes opcode/op and drives every datapath, PC, address-register and memory control.
module risc_controller #(
  parameter logic HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mdata,
  output logic [1:0]  mem_cmd,
  output logic        addr_sel,
  output logic        load_addr,
  output logic        load_pc,
  output logic        reset_pc,
  output logic [1:0]  wb_sel,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [2:0]  r_addr,
  output logic        en_A,
  output logic        en_B,
  output logic [1:0]  shift_op,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  ALU_op,
  output logic        en_C,
  output logic        en_status,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_RESET     = 5'd0,
    S_IF1       = 5'd1,
    S_IF2       = 5'd2,
    S_UPDATE_PC = 5'd3,
    S_DECODE    = 5'd4,
    S_WR_IMM    = 5'd5,
    S_GET_A     = 5'd6,
    S_GET_B     = 5'd7,
    S_ALU       = 5'd8,
    S_WR        = 5'd9,
    S_CMP       = 5'd10,
    S_ADDR      = 5'd11,
    S_LD_ADDR   = 5'd12,
    S_RD_MEM    = 5'd13,
    S_WB_MEM    = 5'd14,
    S_GET_RD    = 5'd15,
    S_PASS      = 5'd16,
    S_WR_MEM    = 5'd17,
    S_HALT      = 5'd18
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        load_ir;

  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;

  assign opc    = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

  // State and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state: fetch sequence, decode dispatch and per-class execution paths.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:     state_d = S_IF1;
      S_IF1:       state_d = S_IF2;
      S_IF2:       state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_DECODE;
      S_DECODE: begin
        casez ({opc, op})
          5'b110_10: state_d = S_WR_IMM;
          5'b110_00: state_d = S_GET_B;
          5'b101_11: state_d = S_GET_B;
          5'b101_??: state_d = S_GET_A;
          5'b011_00: state_d = S_GET_A;
          5'b100_00: state_d = S_GET_A;
          5'b111_??: state_d = S_HALT;
          default:   state_d = HALT_ON_ILLEGAL ? S_HALT : S_IF1;
        endcase
      end
      S_GET_A: begin
        if (opc == 3'b101) begin
          state_d = S_GET_B;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_GET_B: begin
        if ((opc == 3'b101) && (op == 2'b01)) begin
          state_d = S_CMP;
        end else begin
          state_d = S_ALU;
        end
      end
      S_ALU:       state_d = S_WR;
      S_WR:        state_d = S_IF1;
      S_CMP:       state_d = S_IF1;
      S_WR_IMM:    state_d = S_IF1;
      S_ADDR:      state_d = S_LD_ADDR;
      S_LD_ADDR: begin
        if (opc == 3'b011) begin
          state_d = S_RD_MEM;
        end else begin
          state_d = S_GET_RD;
        end
      end
      S_RD_MEM:    state_d = S_WB_MEM;
      S_WB_MEM:    state_d = S_IF1;
      S_GET_RD:    state_d = S_PASS;
      S_PASS:      state_d = S_WR_MEM;
      S_WR_MEM:    state_d = S_IF1;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_RESET;
    endcase
  end

  // Moore outputs; register addresses and ALU/shift ops come from IR fields.
  always_comb begin
    mem_cmd   = MEM_NONE;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    wb_sel    = 2'b00;
    w_addr    = 3'b000;
    w_en      = 1'b0;
    r_addr    = 3'b000;
    en_A      = 1'b0;
    en_B      = 1'b0;
    shift_op  = 2'b00;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    ALU_op    = 2'b00;
    en_C      = 1'b0;
    en_status = 1'b0;
    halted    = 1'b0;
    load_ir   = 1'b0;
    case (state_q)
      S_RESET: begin
        // Held inactive while rst_n is low so nothing in the datapath moves.
        if (rst_n) begin
          load_pc  = 1'b1;
          reset_pc = 1'b1;
        end else begin
          load_pc  = 1'b0;
          reset_pc = 1'b0;
        end
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPDATE_PC: load_pc = 1'b1;
      S_DECODE:    halted  = 1'b0;
      S_WR_IMM: begin
        w_addr = rn;
        wb_sel = 2'b10;
        w_en   = 1'b1;
      end
      S_GET_A: begin
        r_addr = rn;
        en_A   = 1'b1;
      end
      S_GET_B: begin
        r_addr = rm;
        en_B   = 1'b1;
      end
      S_ALU: begin
        // MOV reg adds shifted B to a forced-zero A; the rest use op directly.
        shift_op = sh;
        sel_A    = (opc == 3'b110);
        ALU_op   = (opc == 3'b110) ? 2'b00 : op;
        en_C     = 1'b1;
      end
      S_WR: begin
        w_addr = rd;
        wb_sel = 2'b00;
        w_en   = 1'b1;
      end
      S_CMP: begin
        shift_op  = sh;
        ALU_op    = 2'b01;
        en_status = 1'b1;
      end
      S_ADDR: begin
        sel_B  = 1'b1;
        ALU_op = 2'b00;
        en_C   = 1'b1;
      end
      S_LD_ADDR: load_addr = 1'b1;
      S_RD_MEM: begin
        addr_sel = 1'b0;
        mem_cmd  = MEM_READ;
      end
      S_WB_MEM: begin
        addr_sel = 1'b0;
        mem_cmd  = MEM_READ;
        wb_sel   = 2'b11;
        w_addr   = rd;
        w_en     = 1'b1;
      end
      S_GET_RD: begin
        r_addr = rd;
        en_B   = 1'b1;
      end
      S_PASS: begin
        sel_A = 1'b1;
        en_C  = 1'b1;
      end
      S_WR_MEM: begin
        addr_sel = 1'b0;
        mem_cmd  = MEM_WRITE;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  // Instruction register capture during the second fetch cycle.
  always_comb begin
    if (load_ir) begin
      ir_d = mdata;
    end else begin
      ir_d = ir_q;
    end
  end

endmodule
